// File: rtl/game_pkg.sv
// game_pkg: shared state type and parameter defaults for the
// board-game turn controller.
package game_pkg;

    localparam int GAME_MAX_PLAYERS = 4;
    localparam int GAME_MIN_PLAYERS = 2;
    localparam int GAME_KEY_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ARM   = 3'd2,
        ST_FLIP  = 3'd3,
        ST_JUDGE = 3'd4,
        ST_MISS  = 3'd5,
        ST_MOVE  = 3'd6,
        ST_DONE  = 3'd7
    } game_state_e;

endpackage

// File: rtl/game_turn_fsm_timer.sv
// turn_timer: counts enabled ticks and pulses tc_o on the tick that
// reaches TIMEOUT_TICKS; clr_i holds the count at zero.
module turn_timer #(
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_turn_fsm.sv
// game_turn_fsm: sequences setup, card flips, match judgement and turn
// rotation; tracks every player's position and declares the winner.
module game_turn_fsm
    import game_pkg::*;
#(
    parameter int MAX_PLAYERS   = GAME_MAX_PLAYERS,
    parameter int MIN_PLAYERS   = GAME_MIN_PLAYERS,
    parameter int TRACK_LEN     = 24,
    parameter int KEY_W         = GAME_KEY_W,
    parameter int TIMEOUT_TICKS = 10,
    localparam int PID_W = (MAX_PLAYERS > 1) ? $clog2(MAX_PLAYERS) : 1,
    localparam int POS_W = $clog2(TRACK_LEN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [KEY_W-1:0]             key,
    input  logic                         key_vld,
    input  logic                         cont,
    input  logic                         match_vld,
    input  logic                         match,
    input  logic                         tick,
    input  logic                         abort,
    output logic                         setup_wr,
    output logic                         await_flip,
    output logic                         advance,
    output logic                         timeout,
    output logic [PID_W-1:0]             cur_player,
    output logic [PID_W:0]               num_players,
    output logic [MAX_PLAYERS*POS_W-1:0] pos_bus,
    output logic                         winner_vld,
    output logic [PID_W-1:0]             winner
);

    localparam logic [KEY_W-1:0] KEY_MIN  = KEY_W'(MIN_PLAYERS);
    localparam logic [KEY_W-1:0] KEY_MAX  = KEY_W'(MAX_PLAYERS);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(TRACK_LEN - 1);

    game_state_e      state_q, state_d;
    logic [PID_W-1:0] cur_q, cur_d;
    logic [PID_W:0]   np_q, np_d;
    logic [PID_W-1:0] win_q, win_d;
    logic             timeout_q, timeout_d;
    logic [POS_W-1:0] pos_q [MAX_PLAYERS];
    logic [POS_W-1:0] pos_d [MAX_PLAYERS];

    logic             pos_clr;
    logic             pos_inc;
    logic [POS_W-1:0] cur_pos;
    logic [POS_W-1:0] next_pos;
    logic             key_ok;
    logic             key_flip;
    logic             last_pl;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_tc;

    assign tmr_clr = (state_q != ST_FLIP);
    assign tmr_en  = tick && (state_q == ST_FLIP);

    turn_timer #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(tmr_clr),
        .en_i (tmr_en),
        .tc_o (tmr_tc)
    );

    always_comb begin
        cur_pos = '0;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            if (PID_W'(i) == cur_q) begin
                cur_pos = pos_q[i];
            end
        end
    end

    assign next_pos = cur_pos + 1'b1;
    assign key_ok   = (key >= KEY_MIN) && (key <= KEY_MAX);
    assign key_flip = key_vld && (key != '0);
    assign last_pl  = ({1'b0, cur_q} == (np_q - 1'b1));

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        np_d      = np_q;
        win_d     = win_q;
        timeout_d = 1'b0;
        pos_clr   = 1'b0;
        pos_inc   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_SETUP;
                        cur_d   = '0;
                        win_d   = '0;
                        pos_clr = 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (key_vld && key_ok) begin
                        np_d    = (PID_W+1)'(key);
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (cont) state_d = ST_FLIP;
                end
                // A valid key beats a coincident final tick.
                ST_FLIP: begin
                    if (key_flip) begin
                        state_d = ST_JUDGE;
                    end else if (tmr_tc) begin
                        state_d   = ST_MISS;
                        timeout_d = 1'b1;
                    end
                end
                ST_JUDGE: begin
                    if (match_vld) begin
                        state_d = match ? ST_MOVE : ST_MISS;
                    end
                end
                ST_MISS: begin
                    if (cont) begin
                        cur_d   = last_pl ? '0 : cur_q + 1'b1;
                        state_d = ST_FLIP;
                    end
                end
                ST_MOVE: begin
                    pos_inc = 1'b1;
                    if (next_pos == POS_LAST) begin
                        win_d   = cur_q;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FLIP;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            pos_d[i] = pos_q[i];
            if (pos_clr) begin
                pos_d[i] = '0;
            end else if (pos_inc && (PID_W'(i) == cur_q)) begin
                pos_d[i] = next_pos;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            np_q      <= '0;
            win_q     <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            np_q      <= np_d;
            win_q     <= win_d;
            timeout_q <= timeout_d;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    always_comb begin
        pos_bus = '0;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            pos_bus[i*POS_W +: POS_W] = pos_q[i];
        end
    end

    assign setup_wr    = (state_q == ST_IDLE) || (state_q == ST_SETUP);
    assign await_flip  = (state_q == ST_FLIP);
    assign advance     = (state_q == ST_MOVE);
    assign winner_vld  = (state_q == ST_DONE);
    assign timeout     = timeout_q;
    assign cur_player  = cur_q;
    assign num_players = np_q;
    assign winner      = win_q;

endmodule
